// File: rtl/demux1xn_stream_if.sv
// rtl/demux1xn_stream_if.sv - input stream and per-channel output handshake bundle for demux1xn_stream
interface demux1xn_stream_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2
);
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux1xn_stream.sv
// rtl/demux1xn_stream.sv - registered 1-to-N stream demultiplexer with per-channel holding registers
module demux1xn_stream #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    demux1xn_stream_if.slave     bus,
    output logic                 sel_err,
    output logic [CNT_W-1:0]     acc_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

    ch_state_e        state_q [N_OUT];
    ch_state_e        state_d [N_OUT];
    logic [WIDTH-1:0] data_q  [N_OUT];
    logic [N_OUT-1:0] load;
    logic [N_OUT-1:0] hit;
    logic             in_ready_c;
    logic             sel_ok;
    logic             accept;

    // Out-of-range selects match no channel, so in_ready stays 1 and the word is sunk.
    always_comb begin
        in_ready_c = 1'b1;
        sel_ok     = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (32'(bus.in_sel) == k) begin
                in_ready_c = (state_q[k] == EMPTY) | bus.out_ready[k];
                sel_ok     = 1'b1;
            end
        end
    end

    assign accept       = bus.in_valid & in_ready_c;
    assign bus.in_ready = in_ready_c;

    always_comb begin
        hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (accept && (32'(bus.in_sel) == k)) begin
                hit[k] = 1'b1;
            end
        end
    end

    always_comb begin
        load = '0;
        for (int k = 0; k < N_OUT; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                EMPTY: begin
                    if (hit[k]) begin
                        state_d[k] = FULL;
                        load[k]    = 1'b1;
                    end
                end
                FULL: begin
                    // A hit while FULL implies out_ready[k]: replace in place with no bubble.
                    if (hit[k]) begin
                        load[k] = 1'b1;
                    end else if (bus.out_ready[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            sel_err <= 1'b0;
            acc_cnt <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                state_q[k] <= state_d[k];
                if (load[k]) begin
                    data_q[k] <= bus.in_data;
                end
            end
            sel_err <= accept & ~sel_ok;
            if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign bus.out_data[k*WIDTH +: WIDTH] = data_q[k];
        assign bus.out_valid[k]               = (state_q[k] == FULL);
    end
endmodule

// File: tb/tb_demux1xn_stream.sv
// tb/tb_demux1xn_stream.sv - scoreboard bench for demux1xn_stream (4-channel and 3-channel/4-bit-counter instances)
module tb_demux1xn_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    always #5 clk = ~clk;

    demux1xn_stream_if #(.WIDTH(8), .N_OUT(4), .SEL_W(2)) bus0 ();
    demux1xn_stream_if #(.WIDTH(8), .N_OUT(3), .SEL_W(2)) bus1 ();
    logic        sel_err0, sel_err1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    demux1xn_stream #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .sel_err(sel_err0), .acc_cnt(cnt0));
    demux1xn_stream #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sel_err(sel_err1), .acc_cnt(cnt1));

    logic [7:0]  d_data  [2];
    logic [1:0]  d_sel   [2];
    logic        d_valid [2];
    logic [3:0]  d_ready [2];
    logic [3:0]  ov [2];
    logic [31:0] od [2];
    logic        ir [2];
    logic        se [2];
    logic [15:0] ac [2];

    assign bus0.in_data   = d_data[0];
    assign bus0.in_sel    = d_sel[0];
    assign bus0.in_valid  = d_valid[0];
    assign bus0.out_ready = d_ready[0];
    assign bus1.in_data   = d_data[1];
    assign bus1.in_sel    = d_sel[1];
    assign bus1.in_valid  = d_valid[1];
    assign bus1.out_ready = d_ready[1][2:0];
    assign ov[0] = bus0.out_valid;
    assign ov[1] = {1'b0, bus1.out_valid};
    assign od[0] = bus0.out_data;
    assign od[1] = {8'h00, bus1.out_data};
    assign ir[0] = bus0.in_ready;
    assign ir[1] = bus1.in_ready;
    assign se[0] = sel_err0;
    assign se[1] = sel_err1;
    assign ac[0] = cnt0;
    assign ac[1] = {12'h000, cnt1};

    // Reference model: each channel is a queue of at most one word; counters are plain modular integers.
    logic [7:0] exp_q [2][4][$];
    int         n_ch  [2] = '{4, 3};
    int         cnt_w [2] = '{16, 4};
    int         exp_cnt [2] = '{0, 0};
    logic       exp_err [2] = '{1'b0, 1'b0};
    logic       clean [2][4];
    logic       took  [2] = '{1'b0, 1'b0};
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic exp_ir;
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                exp_ir = (int'(d_sel[i]) >= n_ch[i]) || (exp_q[i][d_sel[i]].size() == 0)
                         || d_ready[i][d_sel[i]];
                chk("in_ready", i, 32'(ir[i]), 32'(exp_ir));
                chk("sel_err", i, 32'(se[i]), 32'(exp_err[i]));
                chk("acc_cnt", i, 32'(ac[i]), 32'(exp_cnt[i]));
                for (int k = 0; k < n_ch[i]; k++) begin
                    chk($sformatf("out_valid[%0d]", k), i, 32'(ov[i][k]), 32'(exp_q[i][k].size() != 0));
                    if (exp_q[i][k].size() != 0) begin
                        chk($sformatf("out_data[%0d]", k), i, 32'(od[i][k*8 +: 8]), 32'(exp_q[i][k][0]));
                        if (d_ready[i][k]) begin
                            void'(exp_q[i][k].pop_front());
                        end
                    end else if (clean[i][k]) begin
                        chk($sformatf("out_data_clr[%0d]", k), i, 32'(od[i][k*8 +: 8]), 32'h0);
                    end
                end
            end
        end
    end

    // Records what the DUT took at the coming edge, sampled just after the monitor has run.
    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    exp_q[i][k].delete();
                    clean[i][k] = 1'b1;
                end
                exp_cnt[i] = 0;
                exp_err[i] = 1'b0;
                took[i]    = 1'b0;
            end else begin
                took[i]    = d_valid[i] && ir[i];
                exp_err[i] = took[i] && (int'(d_sel[i]) >= n_ch[i]);
                if (took[i]) begin
                    exp_cnt[i] = (exp_cnt[i] + 1) % (1 << cnt_w[i]);
                    if (int'(d_sel[i]) < n_ch[i]) begin
                        exp_q[i][d_sel[i]].push_back(d_data[i]);
                        clean[i][d_sel[i]] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        d_valid[i] = v;
        d_sel[i]   = s;
        d_data[i]  = d;
        d_ready[i] = r;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            set_in(i, 1'b0, 2'd0, 8'h00, 4'h0);
            for (int k = 0; k < 4; k++) clean[i][k] = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        set_in(0, 1'b1, 2'd2, 8'hA5, 4'b0000);
        tick();
        set_in(0, 1'b0, 2'd2, 8'hA5, 4'b0000);
        tick();
        set_in(0, 1'b1, 2'd2, 8'h3C, 4'b0000);
        tick();
        tick();
        set_in(0, 1'b1, 2'd2, 8'h3C, 4'b0100);
        tick();
        set_in(0, 1'b1, 2'd0, 8'h11, 4'b0000);
        set_in(1, 1'b1, 2'd3, 8'hFF, 4'b0000);
        tick();
        set_in(0, 1'b0, 2'd0, 8'h11, 4'b0000);
        set_in(1, 1'b0, 2'd3, 8'hFF, 4'b0000);
        tick();
        for (int s = 0; s < 4; s++) begin
            set_in(0, 1'b1, 2'(s), 8'($urandom), 4'b1111);
            tick();
        end
        set_in(0, 1'b0, 2'd0, 8'h00, 4'b1111);
        tick();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(d_valid[i] && !took[i])) begin
                    d_valid[i] = ($urandom_range(0, 3) != 0);
                    d_sel[i]   = 2'($urandom);
                    d_data[i]  = 8'($urandom);
                end
                d_ready[i] = (c >= 190 && c <= 200) ? 4'h0 : 4'($urandom);
            end
            if (c == 200) begin
                d_valid[0] = 1'b1;
                d_valid[1] = 1'b1;
            end
            rst = (c == 200);
            tick();
        end
        rst = 1'b0;
        set_in(0, 1'b0, 2'd0, 8'h00, 4'hF);
        set_in(1, 1'b0, 2'd0, 8'h00, 4'hF);
        tick();
        tick();
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
